// File: rtl/dm_responder_if.sv
// Request/response bundle between the MEM stage and the multi-cycle data memory.
// The master is the pipeline side and the slave is the responder.
interface dm_responder_if;
    logic [31:0] data_address;
    logic [31:0] data_in;
    logic        dm_r;
    logic        dm_w;
    logic [31:0] data_out;
    logic        dm_busy;
    logic        dm_done;
    logic        dm_misalign;

    modport master (
        output data_address, data_in, dm_r, dm_w,
        input  data_out, dm_busy, dm_done, dm_misalign
    );

    modport slave (
        input  data_address, data_in, dm_r, dm_w,
        output data_out, dm_busy, dm_done, dm_misalign
    );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data memory: a request takes LATENCY+2 cycles (LATENCY+1 stalled, then a done pulse).
// Backpressure is the combinational dm_busy stall; requests presented in the DONE cycle are ignored.
module dm_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [31:0]   rdata_q;
    logic          done_q;
    logic          mis_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic          aligned;
    logic          access;
    logic [AW-1:0] idx;
    logic          unused_addr_hi;

    assign req      = bus.dm_r | bus.dm_w;
    assign idx      = addr_q[AW+1:2];
    assign aligned  = (addr_q[1:0] == 2'b00);
    assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
    // Upper address bits are dropped so accesses wrap modulo the memory size.
    assign unused_addr_hi = ^bus.data_address[31:AW+2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    mis_q  <= 1'b0;
                    if (req) begin
                        addr_q  <= bus.data_address[AW+1:0];
                        wdata_q <= bus.data_in;
                        we_q    <= bus.dm_w;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // Read-before-write: stores return the word's prior contents.
                        rdata_q <= aligned ? mem[idx] : 32'd0;
                        done_q  <= 1'b1;
                        mis_q   <= ~aligned;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    mis_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Storage is never cleared; a reset landing on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && access && aligned && we_q) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.data_out    = rdata_q;
    assign bus.dm_done     = done_q;
    assign bus.dm_misalign = mis_q;
    assign bus.dm_busy     = ((state_q == IDLE) && req) || (state_q == BUSY);
endmodule

// File: tb/tb_dm_responder.sv
// Randomized and directed checks of dm_responder against a word-array reference model.
// Expected load results are queued at issue; a monitor pops them on every dm_done.
module tb_dm_responder;
    localparam int LAT = 3;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    dm_responder_if bus ();

    dm_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model [1024];
    logic [31:0] exp_data_q [$];
    logic        exp_mis_q  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference behaviour: word array indexed modulo 1024, read-before-write, misaligned is a no-op.
    task automatic model_issue(input logic [31:0] addr, input logic [31:0] din, input logic w);
        int i;
        i = int'(addr[11:2]);
        if (addr[1:0] != 2'b00) begin
            exp_data_q.push_back(32'd0);
            exp_mis_q.push_back(1'b1);
        end else begin
            exp_data_q.push_back(model[i]);
            exp_mis_q.push_back(1'b0);
            if (w) model[i] = din;
        end
    endtask

    // Runs from the cycle the request is first visible until its dm_done cycle.
    task automatic wait_done();
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.dm_done) break;
            check("busy_during_access", 32'(bus.dm_busy), 32'd1);
            cyc++;
            if (cyc > 40) begin
                checks++;
                failures++;
                $display("FAIL done_timeout actual=none required=dm_done");
                break;
            end
        end
        check("done_cycle", 32'(cyc), 32'(LAT + 1));
        check("busy_in_done", 32'(bus.dm_busy), 32'd0);
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [31:0] din, input logic r, input logic w);
        @(posedge clk);
        #1;
        bus.data_address = addr;
        bus.data_in      = din;
        bus.dm_r         = r;
        bus.dm_w         = w;
        model_issue(addr, din, w);
        wait_done();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            bus.dm_r = 1'b0;
            bus.dm_w = 1'b0;
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.dm_done) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=dm_done required=no_done");
            end else begin
                check("data_out", bus.data_out, exp_data_q.pop_front());
                check("misalign", 32'(bus.dm_misalign), 32'(exp_mis_q.pop_front()));
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        r;
        logic        w;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) model[i] = 32'd0;

        bus.data_address = 32'd0;
        bus.data_in      = 32'd0;
        bus.dm_r         = 1'b1;
        bus.dm_w         = 1'b0;
        reset            = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_data_out", bus.data_out, 32'd0);
            check("rst_done", 32'(bus.dm_done), 32'd0);
            check("rst_misalign", 32'(bus.dm_misalign), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        // The load of address 0 held across reset is live from the first released cycle.
        model_issue(32'd0, 32'd0, 1'b0);
        wait_done();
        idle(2);

        do_req(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1);
        do_req(32'h0000_0010, 32'h0,         1'b1, 1'b0);
        idle(1);

        do_req(32'h0000_0008, 32'h1111_1111, 1'b0, 1'b1);
        do_req(32'h0000_0008, 32'h2222_2222, 1'b1, 1'b1);
        do_req(32'h0000_0008, 32'h0,         1'b1, 1'b0);
        check("rw_store_landed", model[2], 32'h2222_2222);

        do_req(32'h0000_0006, 32'hAAAA_AAAA, 1'b0, 1'b1);
        do_req(32'h0000_0004, 32'h0,         1'b1, 1'b0);
        do_req(32'h0000_0008, 32'h0,         1'b1, 1'b0);

        do_req(32'h0000_1004, 32'h0000_0005, 1'b0, 1'b1);
        do_req(32'h0000_0004, 32'h0,         1'b1, 1'b0);
        idle(1);

        // Store aborted by reset in its second BUSY cycle.
        @(posedge clk);
        #1;
        bus.data_address = 32'h0000_0020;
        bus.data_in      = 32'h0000_0077;
        bus.dm_r         = 1'b0;
        bus.dm_w         = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.dm_w  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.dm_done), 32'd0);
            check("abort_idle", 32'(bus.dm_busy), 32'd0);
        end
        do_req(32'h0000_0020, 32'h0, 1'b1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            a = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0,
                 7'd0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d = $urandom;
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            do_req(a, d, r, w);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);
        check("queue_drained", 32'(exp_data_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
